// File: rtl/tis_stack_node.sv
// tis_stack_node: LIFO stack node answering pushes and pops on four directional valid/ready links.
module tis_stack_node #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 15,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] left_in_data,
    input  logic [DATA_W-1:0] right_in_data,
    input  logic [DATA_W-1:0] up_in_data,
    input  logic [DATA_W-1:0] down_in_data,
    input  logic              left_in_valid,
    input  logic              right_in_valid,
    input  logic              up_in_valid,
    input  logic              down_in_valid,
    output logic              left_in_ready,
    output logic              right_in_ready,
    output logic              up_in_ready,
    output logic              down_in_ready,
    output logic [DATA_W-1:0] left_out_data,
    output logic [DATA_W-1:0] right_out_data,
    output logic [DATA_W-1:0] up_out_data,
    output logic [DATA_W-1:0] down_out_data,
    output logic              left_out_valid,
    output logic              right_out_valid,
    output logic              up_out_valid,
    output logic              down_out_valid,
    input  logic              left_out_ready,
    input  logic              right_out_ready,
    input  logic              up_out_ready,
    input  logic              down_out_ready,
    output logic [CNT_W-1:0]  count
);
    localparam logic [1:0] LEFT = 2'd0, RIGHT = 2'd1, UP = 2'd2, DOWN = 2'd3;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] top, push_data;
    logic [CNT_W-1:0] sp;
    logic [1:0] out_sel, nxt_sel, scan_sel, push_sel;
    logic [3:0] in_valid, out_ready, in_rdy, out_vld;
    logic scan_hit, empty, full, pop_fire, push_fire;
    assign in_valid  = {down_in_valid, up_in_valid, right_in_valid, left_in_valid};
    assign out_ready = {down_out_ready, up_out_ready, right_out_ready, left_out_ready};
    assign empty     = sp == '0;
    assign full      = sp == CNT_W'(DEPTH);
    assign top       = empty ? '0 : mem[sp - 1'b1];
    assign out_vld   = empty ? 4'b0 : 4'b1 << out_sel;
    assign pop_fire  = !empty && out_ready[out_sel];
    assign push_sel  = in_valid[0] ? LEFT : in_valid[1] ? RIGHT : in_valid[2] ? UP : DOWN;
    // A pop handshake wins over any push request; reset also blocks a half-done push.
    assign in_rdy    = (|in_valid && !full && !pop_fire && !reset) ? 4'b1 << push_sel : 4'b0;
    assign push_fire = |in_rdy;
    assign push_data = push_sel == LEFT ? left_in_data : push_sel == RIGHT ? right_in_data :
                       push_sel == UP ? up_in_data : down_in_data;
    always_comb begin
        scan_hit = 1'b0;
        scan_sel = out_sel;
        for (int k = 4; k >= 1; k--)
            if (out_ready[out_sel + 2'(k)]) begin
                scan_hit = 1'b1;
                scan_sel = out_sel + 2'(k);
            end
        nxt_sel = pop_fire ? (scan_hit ? scan_sel : out_sel + 2'd1) :
                  (!out_ready[out_sel] && scan_hit) ? scan_sel : out_sel;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sp      <= '0;
            out_sel <= LEFT;
        end else begin
            out_sel <= nxt_sel;
            if (pop_fire) sp <= sp - 1'b1;
            else if (push_fire) sp <= sp + 1'b1;
        end
    always_ff @(posedge clk)
        if (push_fire) mem[sp] <= push_data;
    assign {down_in_ready, up_in_ready, right_in_ready, left_in_ready}     = in_rdy;
    assign {down_out_valid, up_out_valid, right_out_valid, left_out_valid} = out_vld;
    assign left_out_data  = top;
    assign right_out_data = top;
    assign up_out_data    = top;
    assign down_out_data  = top;
    assign count          = sp;
endmodule

// File: doc/tis_stack_node.md
Name: tis_stack_node

Overview:
- Stack-memory node for the TIS-100 grid, instantiated in place of a compute node at a tile position.
- Acts as the responder on the four directional valid/ready links that a compute node's direction manager drives.
- Writes arriving on any of LEFT/RIGHT/UP/DOWN push an 11-bit signed word onto an internal LIFO.
- Reads requested on any direction pop the top word; one transfer completes per cycle at most.

Parameters:
- DATA_W, 11, word width (signed, -999..999 range owned by writer).
- DEPTH, 15, stack capacity in words.
- CNT_W, 4, width of count output (must satisfy 2^CNT_W > DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- left_in_data / right_in_data / up_in_data / down_in_data  in  DATA_W each  word offered by neighbour for push.
- left_in_valid / right_in_valid / up_in_valid / down_in_valid  in  1 each  neighbour has a word to push.
- left_in_ready / right_in_ready / up_in_ready / down_in_ready  out  1 each  push accepted this cycle.
- left_out_data / right_out_data / up_out_data / down_out_data  out  DATA_W each  top-of-stack word.
- left_out_valid / right_out_valid / up_out_valid / down_out_valid  out  1 each  top word offered to that direction.
- left_out_ready / right_out_ready / up_out_ready / down_out_ready  in  1 each  neighbour is blocked reading from this node.
- count  out  CNT_W  current number of stored words.

Behaviour:
- Storage: mem[0..DEPTH-1] plus stack pointer sp (0..DEPTH); count = sp; top = mem[sp-1].
- Reset (async): sp=0, out_sel=LEFT; all *_in_ready=0, all *_out_valid=0, all *_out_data=0, count=0. Memory contents are not reset. Reset mid-transfer discards the transfer, and no partial push occurs.
- Out data: all four *_out_data = top when sp>0, else 0. Combinational from registers.
- Pop offer: out_sel is a 2-bit registered direction (LEFT=0, RIGHT=1, UP=2, DOWN=3).
  - dir_out_valid = (sp>0) && (out_sel==dir). At most one out_valid is high at any time.
- Pop fires when the offered direction's out_ready=1. Next edge: sp<=sp-1.
- out_sel update each edge:
  - If pop fired: advance to the next direction in the order out_sel+1, +2, +3, +0 (wrapping) whose out_ready is high at that edge. If none is high, advance by 1.
  - If no pop and out_ready[out_sel]=0: move to the first direction with out_ready high, scanning out_sel+1 onward with wrap. If none is high, hold.
  - This gives round-robin fairness: every blocked reader is served within 4 pops.
- Valid may drop without a transfer. Readers in this design hold ready until served, so this is legal on these links.
- Push: push_sel = first of LEFT, RIGHT, UP, DOWN with in_valid=1 (fixed priority).
  - dir_in_ready = (dir==push_sel) && any in_valid && (sp<DEPTH) && !pop_fire. At most one in_ready is high.
  - in_ready depends combinationally on in_valid and out_ready; the design allows this.
- Push fires when in_valid & in_ready. Next edge: mem[sp]<=data, sp<=sp+1.
- Simultaneous push request and pop handshake: the pop wins and all in_ready are 0. The writer retries next cycle.
- Full (sp==DEPTH): all in_ready=0; pops proceed normally.
- Empty (sp==0): all out_valid=0; pushes proceed normally.
- Push then pop: a word pushed at edge N is poppable with out_valid high in cycle N+1. Latency is 1 cycle.
- Never overflows or underflows; count stays within 0..DEPTH.

Test Plan:
- Push/pop order: after reset, LEFT pushes 5, 7, -3 on consecutive cycles. Then with RIGHT out_ready held, RIGHT receives -3, 7, 5, count goes 3→0, and right_out_valid drops when empty.
- Full: 15 pushes of 1..15 from UP. The 16th push has up_in_ready=0 with count=15. One DOWN pop returns 15, then up_in_ready=1 on the next cycle.
- Push arbitration: LEFT=10 and DOWN=20 valid together. left_in_ready=1 and down_in_ready=0; next cycle down_in_ready=1. Stack top is 20, count=2.
- Pop round-robin: stack holds 1, 2, 3, 4 (4 on top), with all four out_ready high from out_sel=LEFT. Pops deliver LEFT=4, RIGHT=3, UP=2, DOWN=1, and exactly one out_valid is high per cycle.
- Push/pop collision: sp=1 with top 9, RIGHT out_ready=1 and UP in_valid with data 6 in the same cycle. RIGHT gets 9 and up_in_ready=0 that cycle; next cycle up_in_ready=1, then top=6.
- Async reset mid-stream: reset asserted between edges with count=3. Immediately count=0 and all valid/ready=0. After release, a pop offer only appears after a new push.
